icache_refill: RTL

Line-refill engine for the VLIW instruction cache. On a cache miss, the core requests a refill; this block fetches one 16-byte line from external memory over a byte-wide read handshake and assembles it into a 128-bit entry. It then presents the entry, with a one-cycle valid strobe, on the icache `new_entry`/`entry_valid` inputs. It sits between the core's miss logic, the external memory bus driven through the multiplexer, and the icache.

---
 rtl/icache_refill.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/icache_refill.sv
// Line-refill engine: fetches one 16-byte line over a byte-wide read handshake and presents it as a 128-bit entry.
// Optional read timeout is enabled by defining ICACHE_REFILL_TIMEOUT_EN.
module icache_refill #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         wb_clk_i,
  input  logic         rst_n,
  input  logic         refill_req,
  input  logic [27:0]  refill_PC,
  input  logic         invalidate,
  output logic [27:0]  mem_addr,
  output logic         mem_rd,
  input  logic [7:0]   mem_data,
  input  logic         mem_ready,
  output logic         busy,
  output logic [127:0] new_entry,
  output logic         entry_valid,
  output logic         refill_err,
  output logic [1:0]   o_dbg_state
);

  // Handshake: a byte transfers on every rising edge where mem_rd and mem_ready
  // are both high; mem_rd and mem_addr stay stable until that edge.

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("icache_refill: TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [3:0]     r_idx;
  logic [3:0]     w_idx_nxt;
  logic [23:0]    r_line_no;
  logic [23:0]    w_line_no_nxt;
  logic           w_accept;
  logic           w_timeout;
  logic           w_err_nxt;
  logic [27:0]    w_addr_nxt;

  logic [27:0]    r_mem_addr;
  logic           r_mem_rd;
  logic           r_busy;
  logic [127:0]   r_line;
  logic           r_entry_valid;
  logic           r_err;

  logic           w_unused_pc_lsb;
  assign w_unused_pc_lsb = ^refill_PC[3:0];

`ifdef ICACHE_REFILL_TIMEOUT_EN
  logic [7:0] r_wait;
  logic [7:0] w_wait_inc;

  assign w_wait_inc = r_wait + 8'd1;
  assign w_timeout  = (r_state == S_READ) && !mem_ready &&
                      (w_wait_inc == 8'(TIMEOUT_CYCLES));

  // Counts consecutive stalled READ cycles; zero outside READ so entry starts clean.
  always_ff @(posedge wb_clk_i) begin
    if (!rst_n) begin
      r_wait <= 8'd0;
    end else if (r_state != S_READ || mem_ready) begin
      r_wait <= 8'd0;
    end else begin
      r_wait <= w_wait_inc;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_line_no_nxt = r_line_no;
    w_accept      = 1'b0;
    w_err_nxt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (refill_req && !invalidate) begin
          w_state_nxt   = S_READ;
          w_line_no_nxt = refill_PC[27:4];
          w_idx_nxt     = 4'd0;
        end
      end
      S_READ: begin
        if (invalidate) begin
          w_state_nxt = S_IDLE;
        end else if (mem_ready) begin
          w_accept = 1'b1;
          if (r_idx == 4'hF) begin
            w_state_nxt = S_DONE;
          end else begin
            w_idx_nxt = r_idx + 4'd1;
          end
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
          w_err_nxt   = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Base is line-aligned, so adding idx never carries out of the low nibble.
  assign w_addr_nxt = {w_line_no_nxt, 4'h0} + {24'd0, w_idx_nxt};

  always_ff @(posedge wb_clk_i) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_idx         <= 4'd0;
      r_line_no     <= 24'd0;
      r_mem_addr    <= 28'd0;
      r_mem_rd      <= 1'b0;
      r_busy        <= 1'b0;
      r_line        <= 128'd0;
      r_entry_valid <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_line_no     <= w_line_no_nxt;
      r_mem_rd      <= (w_state_nxt == S_READ);
      r_busy        <= (w_state_nxt != S_IDLE);
      r_entry_valid <= (w_state_nxt == S_DONE);
      r_err         <= w_err_nxt;
      if (w_state_nxt == S_READ) begin
        r_mem_addr <= w_addr_nxt;
      end
      if (w_accept) begin
        r_line[{r_idx, 3'b000} +: 8] <= mem_data;
      end
    end
  end

  assign mem_addr    = r_mem_addr;
  assign mem_rd      = r_mem_rd;
  assign busy        = r_busy;
  assign new_entry   = r_line;
  // An invalidate arriving in the DONE cycle must still cancel the strobe.
  assign entry_valid = r_entry_valid && !invalidate;
  assign refill_err  = r_err;
  assign o_dbg_state = r_state;

endmodule
